hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the 5-stage 16-bit core. Tracks destination tags of in-flight instructions in EX, MEM and WB, and drives the 2-bit selects of the EX-stage 3-input operand muxes (regfile / EX-MEM result / MEM-WB result). Generates load-use stall and branch-flush controls for the PC, IF/ID and ID/EX registers, and keeps saturating stall/flush event counters.

## Interface
- `REG_AW`, 3: register address width (8 architectural registers, r0 hardwired zero).
- `CNT_W`, 16: width of the performance counters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_rs1`, `id_rs2` in REG_AW: ID source registers.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in REG_AW: ID destination register.
- `id_we` in 1: the ID instruction writes `id_rd`.
- `id_mem_read` in 1: the ID instruction is a load.
- `ex_branch_taken` in 1: branch resolved taken in EX this cycle.
- `fwd_a_sel`, `fwd_b_sel` out 2: EX operand mux selects, registered: 0 regfile, 1 EX/MEM, 2 MEM/WB.
- `pc_stall`, `ifid_stall` out 1: hold the PC and IF/ID registers.
- `idex_bubble` out 1: load a NOP into ID/EX.
- `ifid_flush` out 1: clear IF/ID to a NOP.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters.

## Operation
- Tag pipe: three registered tags `ex`, `mem`, `wb`, each {valid, rd, we, mem_read}. Every cycle `wb<=mem`, `mem<=ex`. `ex` loads the ID fields when `id_valid && !idex_bubble`, else it is invalid.
- A tag "writes r" iff valid && we && rd==r && r!=0. r0 never forwards and never stalls.
- Load-use: `hz = ex.valid && ex.mem_read && ex writes (id_rs1 if used) or (id_rs2 if used)`, qualified by `id_valid`.
- Flush: `fl = ex_branch_taken && ex.valid`.
- Outputs (combinational from tags and inputs):
  - `ifid_flush = fl`, `idex_bubble = fl | hz`.
  - `pc_stall = ifid_stall = hz && !fl`.
  - Flush has priority: on simultaneous `fl` and `hz`, no stall, both stages cleared.
- Forward select for each source, computed in ID and registered into `fwd_*_sel` when the ID instruction advances:
  - 1 if the current `ex` tag writes it (result will be in EX/MEM).
  - else 2 if the current `mem` tag writes it (result will be in MEM/WB).
  - else 0.
  - Newest producer wins. An unused source gives 0.
  - On `idex_bubble` or `!id_valid`, both selects register 0.
- After a load-use bubble, the re-evaluated consumer sees the load in `mem` and gets select 2. The regfile performs write-before-read for the WB stage, so `wb` never forwards.
- Counters: `stall_cnt` increments in each cycle with `pc_stall`. `flush_cnt` increments in each cycle with `fl`. Both saturate at all-ones and never wrap.

## Timing
- Reset (async assert, synchronous-to-clk release): all tags invalid, `fwd_*_sel=0`, counters 0. All combinational outputs are therefore 0 during and after reset until a valid tag exists.
- Forward selects: latency 1, valid in the same cycle the instruction occupies EX.
- Stall and flush outputs: latency 0, asserted in the hazard cycle.
- Load-use stall lasts exactly one cycle per hazard. The next cycle re-evaluates with the load in `mem`.
- Flush: one cycle. The EX tag next cycle is invalid. MEM/WB tags of older instructions still retire and forward.
- Reset asserted mid-stall or mid-flush: state is cleared immediately, with no residual bubble after release.

## Structure
- Shared `pipeline_pkg`:
  - `FWD_RF=2'd0`, `FWD_EXMEM=2'd1`, `FWD_MEMWB=2'd2`.
  - Tag struct {valid, rd, we, mem_read}.
  - `REG_AW` default.
- Sub-module `fwd_sel_logic`: pure function of (rs, used, ex tag, mem tag) to select, instantiated twice (A and B).
- The tag pipe, hazard detection and counters live in the top module.

## Test plan
- Back-to-back ALU: `add r1` then `add r3,r1,r2`. The consumer in EX has `fwd_a_sel=1`, `fwd_b_sel=0`, with no stall.
- Gap of one: `add r1`, unrelated, `sub r4,r1,r1`. The consumer in EX has both selects = 2.
- Load-use: `lw r2` then `add r5,r2,r2`.
  - Exactly one cycle of `pc_stall=ifid_stall=idex_bubble=1`.
  - The consumer then enters EX with both selects = 2.
  - `stall_cnt` increments by 1.
- r0 destination: `lw r0` then `add r1,r0,r0`. No stall, selects 0.
- Branch taken in EX, with a load-use hazard in ID in the same cycle:
  - `ifid_flush=idex_bubble=1`, `pc_stall=0`.
  - `flush_cnt` increments by 1, `stall_cnt` unchanged.
  - Next-cycle EX selects are 0.
- Counter saturation with CNT_W=4: 20 load-use stalls leave `stall_cnt=15`. Async reset mid-stall then returns all outputs and counters to 0 immediately.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forward-mux encodings, in-flight destination tag,
// and the "tag writes register" predicate used by hazard and forwarding logic.
package pipeline_pkg;

  localparam int unsigned REG_AW_DEFAULT = 3;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                      valid;
    logic [REG_AW_DEFAULT-1:0] rd;
    logic                      we;
    logic                      mem_read;
  } tag_t;

  // r0 is hardwired zero, so it is never a real producer.
  function automatic logic tag_writes(tag_t tag, logic [REG_AW_DEFAULT-1:0] r);
    return tag.valid && tag.we && (tag.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_logic.sv
// Operand forward select for one EX source, evaluated while the consumer is in ID.
module fwd_sel_logic
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              used,
  input  tag_t              ex_tag,
  input  tag_t              mem_tag,
  output logic [1:0]        sel
);

  // The ex producer is newer than the mem producer, so it is checked first.
  always_comb begin
    sel = FWD_RF;
    if (used) begin
      if (tag_writes(ex_tag, rs))
        sel = FWD_EXMEM;
      else if (tag_writes(mem_tag, rs))
        sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: EX/MEM/WB tag pipe, load-use stall,
// branch flush, registered EX forward selects and saturating event counters.
module hazard_forward_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Index 0 = ex, 1 = mem, 2 = wb. The wb tag is kept for completeness only:
  // the regfile writes before it reads, so wb never forwards.
  tag_t       stage_q [3];
  logic       hz;
  logic       fl;
  logic       advance;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  fwd_sel_logic #(.REG_AW(REG_AW)) u_fwd_a (
    .rs      (id_rs1),
    .used    (id_rs1_used),
    .ex_tag  (stage_q[0]),
    .mem_tag (stage_q[1]),
    .sel     (sel_a)
  );

  fwd_sel_logic #(.REG_AW(REG_AW)) u_fwd_b (
    .rs      (id_rs2),
    .used    (id_rs2_used),
    .ex_tag  (stage_q[0]),
    .mem_tag (stage_q[1]),
    .sel     (sel_b)
  );

  always_comb begin
    hz = id_valid && stage_q[0].valid && stage_q[0].mem_read &&
         ((id_rs1_used && tag_writes(stage_q[0], id_rs1)) ||
          (id_rs2_used && tag_writes(stage_q[0], id_rs2)));
    fl          = ex_branch_taken && stage_q[0].valid;
    ifid_flush  = fl;
    idex_bubble = fl || hz;
    pc_stall    = hz && !fl;
    ifid_stall  = hz && !fl;
    advance     = id_valid && !idex_bubble;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 3; i++) stage_q[i] <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stage_q[2] <= stage_q[1];
      stage_q[1] <= stage_q[0];
      if (advance) begin
        stage_q[0] <= '{valid: 1'b1, rd: id_rd, we: id_we, mem_read: id_mem_read};
        fwd_a_sel  <= sel_a;
        fwd_b_sel  <= sel_b;
      end else begin
        stage_q[0] <= '0;
        fwd_a_sel  <= FWD_RF;
        fwd_b_sel  <= FWD_RF;
      end
      if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (fl && (flush_cnt != '1))       flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl: forwarding, load-use, flush,
// r0 handling, counter saturation and asynchronous reset.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       id_we = 1'b0, id_mem_read = 1'b0, ex_branch_taken = 1'b0;

  logic [1:0]  fwd_a_sel, fwd_b_sel, s_fwd_a_sel, s_fwd_b_sel;
  logic        pc_stall, ifid_stall, idex_bubble, ifid_flush;
  logic        s_pc_stall, s_ifid_stall, s_idex_bubble, s_ifid_flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_forward_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel), .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall),
    .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs1, input logic u1,
                        input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                        input logic we, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_we = we; id_mem_read = mr;
  endtask

  task automatic idle2();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic check_ctl(input string tag, input logic st, input logic bub, input logic flu);
    check({tag, "_pc_stall"}, {15'd0, pc_stall}, {15'd0, st});
    check({tag, "_ifid_stall"}, {15'd0, ifid_stall}, {15'd0, st});
    check({tag, "_bubble"}, {15'd0, idex_bubble}, {15'd0, bub});
    check({tag, "_flush"}, {15'd0, ifid_flush}, {15'd0, flu});
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_sel_a", {14'd0, fwd_a_sel}, 16'd0);
    check("rst_sel_b", {14'd0, fwd_b_sel}, 16'd0);
    check_ctl("rst", 1'b0, 1'b0, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_flush_cnt", flush_cnt, 16'd0);
    tick();
    rst = 1'b1;
    tick();

    // Back-to-back ALU: add r1,r6,r7 ; add r3,r1,r2
    set_id(1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
    #1 check_ctl("b2b", 1'b0, 1'b0, 1'b0);
    tick();
    check("b2b_sel_a", {14'd0, fwd_a_sel}, 16'd1);
    check("b2b_sel_b", {14'd0, fwd_b_sel}, 16'd0);
    idle2();

    // Gap of one: add r1 ; add r6,r7,r7 ; sub r4,r1,r1
    set_id(1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 3'd6, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    tick();
    check("gap_sel_a", {14'd0, fwd_a_sel}, 16'd2);
    check("gap_sel_b", {14'd0, fwd_b_sel}, 16'd2);
    idle2();

    // Newest producer wins; an unused source reads regfile
    set_id(1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd1, 1'b0, 3'd3, 1'b1, 1'b0);
    tick();
    check("newest_sel_a", {14'd0, fwd_a_sel}, 16'd1);
    check("unused_sel_b", {14'd0, fwd_b_sel}, 16'd0);
    idle2();

    // Load-use: lw r2 ; add r5,r2,r2
    set_id(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
    #1 check_ctl("lu_hz", 1'b1, 1'b1, 1'b0);
    tick();
    check_ctl("lu_next", 1'b0, 1'b0, 1'b0);
    check("lu_stall_cnt", stall_cnt, 16'd1);
    tick();
    check("lu_sel_a", {14'd0, fwd_a_sel}, 16'd2);
    check("lu_sel_b", {14'd0, fwd_b_sel}, 16'd2);
    idle2();

    // r0 destination: lw r0 ; add r1,r0,r0
    set_id(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
    #1 check_ctl("r0", 1'b0, 1'b0, 1'b0);
    tick();
    check("r0_sel_a", {14'd0, fwd_a_sel}, 16'd0);
    check("r0_sel_b", {14'd0, fwd_b_sel}, 16'd0);
    check("r0_stall_cnt", stall_cnt, 16'd1);
    idle2();

    // Branch taken with simultaneous load-use: flush wins
    set_id(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1 check_ctl("br", 1'b0, 1'b1, 1'b1);
    tick();
    ex_branch_taken = 1'b0;
    check("br_flush_cnt", flush_cnt, 16'd1);
    check("br_stall_cnt", stall_cnt, 16'd1);
    check("br_sel_a", {14'd0, fwd_a_sel}, 16'd0);
    check("br_sel_b", {14'd0, fwd_b_sel}, 16'd0);
    ex_branch_taken = 1'b1;
    #1 check("br_ex_invalid", {15'd0, ifid_flush}, 16'd0);
    ex_branch_taken = 1'b0;
    idle2();

    // Saturation: 20 load-use stalls
    for (int i = 0; i < 20; i++) begin
      set_id(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
      tick();
    end
    check("sat_small_stall", {12'd0, s_stall_cnt}, 16'd15);
    check("sat_big_stall", stall_cnt, 16'd21);
    check("sat_small_flush", {12'd0, s_flush_cnt}, 16'd1);

    // Async reset mid-stall
    set_id(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
    #1 check("arst_pre_stall", {15'd0, pc_stall}, 16'd1);
    #1 rst = 1'b0;
    #1;
    check_ctl("arst", 1'b0, 1'b0, 1'b0);
    check("arst_stall_cnt", stall_cnt, 16'd0);
    check("arst_flush_cnt", flush_cnt, 16'd0);
    check("arst_small_stall", {12'd0, s_stall_cnt}, 16'd0);
    check("arst_sel_a", {14'd0, fwd_a_sel}, 16'd0);
    check("arst_sel_b", {14'd0, fwd_b_sel}, 16'd0);
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check_ctl("post_rst", 1'b0, 1'b0, 1'b0);
    check("post_rst_stall_cnt", stall_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
